// File: rtl/bram_loader.sv
// Stream-to-BRAM fill stage: writes a PS-started word stream from address 0,
// optionally zero-pads the remainder, then reports done and waits for ack.
module bram_loader #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ps_control,
    output logic [31:0]       pl_status,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wrdata,
    output logic [3:0]        bram_we
);

    localparam int unsigned CNT_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] last_idx, last_nxt;
    logic             pad_en, pad_nxt;
    logic [CNT_W-1:0] count_inc;

    // Only the start bit, L and pad enable are meaningful.
    logic unused_ctrl;
    assign unused_ctrl = ^ps_control[31:13];

    // Saturating increment: the final write lands on NUM_WORDS-1 and must not wrap.
    assign count_inc = (count == LAST_IDX) ? count : count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            last_idx <= '0;
            pad_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            last_idx <= last_nxt;
            pad_en   <= pad_nxt;
        end
    end

    // Next-state, counter and combinational write-port decode.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        last_nxt    = last_idx;
        pad_nxt     = pad_en;
        in_ready    = 1'b0;
        bram_we     = 4'h0;
        bram_wrdata = 32'h0;
        bram_addr   = {count, 2'b00};
        pl_status   = 32'h0;

        unique case (state)
            IDLE: begin
                count_nxt = '0;
                bram_addr = '0;
                if (ps_control[0]) begin
                    last_nxt  = CNT_W'(ps_control[11:1]);
                    pad_nxt   = ps_control[12];
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready     = 1'b1;
                pl_status[1] = 1'b1;
                if (in_valid) begin
                    bram_we     = 4'hf;
                    bram_wrdata = in_data;
                    count_nxt   = count_inc;
                    if (count == last_idx) begin
                        state_nxt = (pad_en && (last_idx != LAST_IDX)) ? PAD : DONE;
                    end
                end
            end
            PAD: begin
                pl_status[1] = 1'b1;
                bram_we      = 4'hf;
                count_nxt    = count_inc;
                if (count == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                pl_status[0] = 1'b1;
                if (!ps_control[0]) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: drives on the falling edge, checks the
// combinational write port just after it, and mirrors writes into a local BRAM.
module tb_bram_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ps_control = 32'h0;
    logic [31:0] pl_status;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [3:0]  bram_we;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    logic [31:0] mem [0:2047];

    always #5 clk = ~clk;

    bram_loader #(.ADDR_W(13), .NUM_WORDS(2048)) dut (
        .clk(clk), .reset(reset), .ps_control(ps_control), .pl_status(pl_status),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_we(bram_we)
    );

    // Behavioural BRAM capturing each full-word write at the clock edge.
    always @(posedge clk) begin
        if (bram_we == 4'hf) begin
            mem[bram_addr[12:2]] <= bram_wrdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic start(input int l, input bit p);
        @(negedge clk);
        ps_control = {19'd0, p, 11'(l), 1'b1};
        in_valid   = 1'b0;
        #1;
    endtask

    task automatic ack();
        @(negedge clk);
        ps_control = 32'h0;
        in_valid   = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (pl_status !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", pl_status); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        total++; if (bram_we !== 4'h0) begin bad++; $display("FAIL reset_we got=%h exp=0", bram_we); end
        total++; if (bram_addr !== 13'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bram_addr); end
        total++; if (bram_wrdata !== 32'h0) begin bad++; $display("FAIL reset_wrdata got=%h exp=0", bram_wrdata); end
        reset = 1'b0;
    endtask

    task automatic test_load_nopad();
        int w0 = wr_count;
        start(3, 1'b0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL np_idle_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(i);
            #1;
            total++;
            if ({bram_we, bram_addr, bram_wrdata, pl_status, in_ready} !==
                {4'hf, 13'(i * 4), 32'hA + 32'(i), 32'd2, 1'b1}) begin
                bad++;
                $display("FAIL np_beat%0d got we=%h addr=%0d data=%h st=%h rdy=%b exp we=f addr=%0d data=%h st=2 rdy=1",
                         i, bram_we, bram_addr, bram_wrdata, pl_status, in_ready, i * 4, 32'hA + 32'(i));
            end
        end
        @(negedge clk);
        #1;
        total++; if (pl_status !== 32'h1) begin bad++; $display("FAIL np_done got=%h exp=1", pl_status); end
        total++; if ({in_ready, bram_we} !== 5'h0) begin bad++; $display("FAIL np_done_port got rdy=%b we=%h exp 0", in_ready, bram_we); end
        ack();
        total++; if (wr_count - w0 !== 4) begin bad++; $display("FAIL np_writes got=%0d exp=4", wr_count - w0); end
        total++; if ({pl_status, bram_addr} !== 45'h0) begin bad++; $display("FAIL np_ack got st=%h addr=%0d exp 0", pl_status, bram_addr); end
    endtask

    task automatic test_stall();
        logic [9:0] pat = 10'b1101101001;
        int n = 0;
        start(5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = pat[i];
            in_data  = 32'h100 + 32'(n);
            #1;
            total++;
            if ({bram_we, bram_addr} !== {(pat[i] ? 4'hf : 4'h0), 13'(n * 4)}) begin
                bad++;
                $display("FAIL stall_cyc%0d got we=%h addr=%0d exp we=%h addr=%0d",
                         i, bram_we, bram_addr, pat[i] ? 4'hf : 4'h0, n * 4);
            end
            if (pat[i]) n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (pl_status !== 32'h1) begin bad++; $display("FAIL stall_done got=%h exp=1", pl_status); end
        total++; if (mem[5] !== 32'h105) begin bad++; $display("FAIL stall_mem5 got=%h exp=105", mem[5]); end
        ack();
    endtask

    task automatic test_full();
        int err = 0;
        int held = 0;
        int w0 = wr_count;
        start(2047, 1'b1);
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(i * 7);
            #1;
            if ({bram_we, bram_addr, bram_wrdata} !== {4'hf, 13'(i * 4), 32'(i * 7)}) err++;
        end
        total++; if (err !== 0) begin bad++; $display("FAIL full_beats got errs=%0d exp=0", err); end
        @(negedge clk);
        #1;
        total++; if ({pl_status, bram_we} !== {32'h1, 4'h0}) begin bad++; $display("FAIL full_nopad got st=%h we=%h exp st=1 we=0", pl_status, bram_we); end
        total++; if (wr_count - w0 !== 2048) begin bad++; $display("FAIL full_writes got=%0d exp=2048", wr_count - w0); end
        total++; if (mem[2047] !== 32'd14329) begin bad++; $display("FAIL full_last got=%0d exp=14329", mem[2047]); end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (pl_status !== 32'h1) held++;
        end
        total++; if (held !== 0) begin bad++; $display("FAIL full_hold got lost=%0d exp=0", held); end
        ack();
        total++; if ({pl_status, in_ready, bram_addr} !== 46'h0) begin bad++; $display("FAIL full_ack got st=%h rdy=%b addr=%0d exp 0", pl_status, in_ready, bram_addr); end
    endtask

    task automatic test_pad();
        int err = 0;
        int k = 0;
        bit fin = 1'b0;
        int w0 = wr_count;
        start(3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(i);
            #1;
            if ({bram_we, bram_addr, bram_wrdata} !== {4'hf, 13'(i * 4), 32'hA + 32'(i)}) err++;
        end
        while (!fin && k < 3000) begin
            @(negedge clk);
            #1;
            if (pl_status[0] === 1'b1) begin
                fin = 1'b1;
            end else begin
                if ({in_ready, bram_we, bram_addr, bram_wrdata, pl_status} !==
                    {1'b0, 4'hf, 13'((4 + k) * 4), 32'h0, 32'd2}) err++;
                k++;
            end
        end
        total++; if (err !== 0) begin bad++; $display("FAIL pad_cycles got errs=%0d exp=0", err); end
        total++; if (k !== 2044) begin bad++; $display("FAIL pad_len got=%0d exp=2044", k); end
        total++; if (wr_count - w0 !== 2048) begin bad++; $display("FAIL pad_writes got=%0d exp=2048", wr_count - w0); end
        total++; if ({mem[3], mem[4], mem[2047]} !== {32'hD, 32'h0, 32'h0}) begin bad++; $display("FAIL pad_mem got %h %h %h exp d 0 0", mem[3], mem[4], mem[2047]); end
        ack();
    endtask

    task automatic test_reset_mid();
        int w0;
        start(10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h50 + 32'(i);
        end
        @(negedge clk);
        reset      = 1'b1;
        ps_control = 32'h0;
        @(negedge clk);
        #1;
        total++; if ({in_ready, bram_we, bram_addr, pl_status} !== 50'h0) begin bad++; $display("FAIL rmid_out got rdy=%b we=%h addr=%0d st=%h exp 0", in_ready, bram_we, bram_addr, pl_status); end
        reset = 1'b0;
        w0 = wr_count;
        start(0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h55;
        #1;
        total++; if ({bram_we, bram_addr} !== {4'hf, 13'h0}) begin bad++; $display("FAIL rmid_l0 got we=%h addr=%0d exp f 0", bram_we, bram_addr); end
        @(negedge clk);
        #1;
        total++; if (pl_status !== 32'h1) begin bad++; $display("FAIL rmid_done got=%h exp=1", pl_status); end
        total++; if (wr_count - w0 !== 1) begin bad++; $display("FAIL rmid_writes got=%0d exp=1", wr_count - w0); end
        ack();
    endtask

    task automatic test_ctrl_change();
        start(2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h70 + 32'(i);
            if (i == 1) ps_control = {19'd0, 1'b1, 11'd0, 1'b1};
            #1;
            total++;
            if ({bram_we, bram_addr, pl_status} !== {4'hf, 13'(i * 4), 32'd2}) begin
                bad++;
                $display("FAIL ctrl_beat%0d got we=%h addr=%0d st=%h exp we=f addr=%0d st=2",
                         i, bram_we, bram_addr, pl_status, i * 4);
            end
        end
        @(negedge clk);
        #1;
        total++; if ({pl_status, bram_we} !== {32'h1, 4'h0}) begin bad++; $display("FAIL ctrl_done got st=%h we=%h exp st=1 we=0", pl_status, bram_we); end
        ack();
    endtask

    initial begin
        test_reset();
        test_load_nopad();
        test_stall();
        test_full();
        test_pad();
        test_reset_mid();
        test_ctrl_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
